uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between up to NUM_REQ byte producers, e.g. the binary counter display path and a status/debug reporter.
- Grants requesters round-robin and latches the winner's byte.
- Starts the transmitter, waits for its done pulse, then enforces a programmable idle gap between frames.
- The gap is counted in baud ticks from the 115200 baud rate generator (16x oversample ticks).

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..4).
- DATA_BITS, 8, byte width per requester.
- GAP_TICKS, 16, baud ticks of idle line after each frame (0 = no gap; 16 = one bit time).
- TIMEOUT_TICKS, 4096, baud ticks allowed between tx_start and tx_done_tick before an error is declared.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- tick  input  1  baud tick from the baud rate generator, one clk wide
- req  input  NUM_REQ  per-requester send request; level, held until granted
- din  input  NUM_REQ*DATA_BITS  requester bytes, requester i at bits [i*DATA_BITS +: DATA_BITS]
- grant  output  NUM_REQ  one-hot, one-clk pulse; the requester's byte has been latched
- tx_start  output  1  one-clk start pulse to the UART transmitter
- tx_data  output  DATA_BITS  byte to the transmitter; stable from tx_start until tx_done_tick
- tx_done_tick  input  1  transmitter end-of-frame pulse
- busy  output  1  high in every state except IDLE
- timeout_err  output  1  sticky; set when the transmitter fails to finish within TIMEOUT_TICKS

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; grant = 0, tx_start = 0, tx_data = 0, busy = 0, timeout_err = 0.
  - Gap and timeout counters = 0.
  - last_grant pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-frame aborts immediately with no further tx_start. The transmitter is assumed to be reset by the same signal.
- States: IDLE, LOAD, START, WAIT_DONE, GAP.
- IDLE:
  - If any req bit is set, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Latch din of the winner into tx_data; pulse grant[winner] in that same cycle; update last_grant; go to LOAD.
  - With no req, stay in IDLE.
- LOAD: one-cycle settle state; go to START.
- START: tx_start = 1 for exactly this cycle; clear the timeout counter; go to WAIT_DONE.
- WAIT_DONE:
  - On tx_done_tick: go to GAP with gap counter = 0. A tick in the same cycle is not counted.
  - On each tick otherwise: increment the timeout counter.
  - When the timeout counter reaches TIMEOUT_TICKS-1 on a tick with no tx_done_tick: set timeout_err and go to GAP, as if the frame had finished.
- GAP:
  - On each tick, increment the gap counter.
  - Leave for IDLE on the tick where gap counter == GAP_TICKS-1.
  - If GAP_TICKS == 0, go from GAP to IDLE on the next clk.
- Latency, from IDLE with req asserted:
  - grant at cycle 0, tx_start at cycle 2.
  - Minimum spacing between grants = frame time + GAP_TICKS ticks + 1 clk (the IDLE evaluation cycle).
- Requester rules:
  - A requester may deassert req the cycle after its grant.
  - A requester that holds req continuously is re-served only after every other active requester has had one grant.
  - req changes outside IDLE are ignored; din is sampled only in the grant cycle.
- tx_data holds its value until the next grant; it is not cleared after the frame.
- timeout_err clears only on reset.
- Counter widths are sized by $clog2 of their parameter; counters never wrap inside a state.
- A tx_done_tick outside WAIT_DONE is ignored.

Test Plan:
- After reset release, req=2'b01, din[7:0]=8'hA5 -> grant=2'b01 at cycle 0, tx_start at cycle 2 with tx_data=8'hA5, busy=1 until 16 ticks after tx_done_tick.
- req=2'b11 held, din={8'h22,8'h11} -> transmitted order 8'h11, 8'h22, 8'h11, 8'h22; grants alternate 01,10,01,10.
- With GAP_TICKS=16, tx_done_tick at clk N -> no grant until the 16th tick after N, and the next grant falls 1 clk after that tick. Repeat with GAP_TICKS=0 -> IDLE 1 clk after entering GAP.
- Never pulse tx_done_tick, TIMEOUT_TICKS=8 -> timeout_err=1 on the 8th tick after tx_start; the arbiter returns to IDLE and serves the next req.
- Assert reset low in WAIT_DONE, then release with req=2'b10 -> all outputs 0 during reset; first grant=2'b10, followed by tx_start.
- tick and tx_done_tick coincident in WAIT_DONE; spurious tx_done_tick in IDLE -> the gap starts from 0, and the spurious pulse causes no state change or grant.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte producers.
// Round-robin grant, byte latch, transmitter start, done/timeout wait, then an
// idle gap counted in baud ticks before the next arbitration.
//
// Handshake: req[i] is a level held by requester i until it sees grant[i], a
// one-clk pulse in the IDLE cycle where din slice i is latched; the requester
// may drop req the following cycle. tx_start is a one-clk pulse; tx_data is
// stable from tx_start until tx_done_tick and holds until the next grant.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int DATA_BITS     = 8,
  parameter int GAP_TICKS     = 16,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_BITS-1:0] din,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         tx_start,
  output logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_done_tick,
  output logic                         busy,
  output logic                         timeout_err,
  output logic [2:0]                   state_dbg
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          last_q, last_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [TW-1:0]          to_q, to_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   err_q, err_d;

  logic                   found;
  logic [IW-1:0]          win;
  logic [IW-1:0]          cand;

  // Round-robin search: first set req bit starting just after the last winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state, counters and pulse outputs; everything holds unless a state acts.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gap_d    = gap_q;
    to_d     = to_q;
    data_d   = data_q;
    err_d    = err_q;
    grant    = '0;
    tx_start = 1'b0;
    case (state_q)
      IDLE: begin
        // reset is included so no grant can show while reset is held
        if (found && reset) begin
          grant[win] = 1'b1;
          data_d     = din[win*DATA_BITS +: DATA_BITS];
          last_d     = win;
          state_d    = LOAD;
        end
      end
      LOAD: state_d = START;
      START: begin
        tx_start = 1'b1;
        to_d     = '0;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        // a tick coinciding with done belongs to neither counter
        if (tx_done_tick) begin
          gap_d   = '0;
          state_d = GAP;
        end else if (tick) begin
          if (to_q == TO_LAST) begin
            err_d   = 1'b1;
            gap_d   = '0;
            state_d = GAP;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (GAP_TICKS == 0) begin
          state_d = IDLE;
        end else if (tick) begin
          if (gap_q == GAP_LAST) state_d = IDLE;
          else                   gap_d   = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; last_q starts at NUM_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      gap_q   <= '0;
      to_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign tx_data     = data_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: dut_a (GAP 16, TIMEOUT 8) carries most scenarios
// with a grant/data scoreboard; dut_b (GAP 0) covers the zero-gap path.
module tb_uart_tx_arbiter;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut_a signals
  logic        tick = 1'b0;
  logic        done = 1'b0;
  logic [1:0]  req  = 2'b00;
  logic [15:0] din  = 16'h0000;
  logic [1:0]  grant_a;
  logic        tx_start_a;
  logic [7:0]  tx_data_a;
  logic        busy_a;
  logic        err_a;
  logic [2:0]  dbg_a;

  // dut_b signals
  logic        tick_b = 1'b0;
  logic        done_b = 1'b0;
  logic [1:0]  req_b  = 2'b00;
  logic [15:0] din_b  = 16'h0000;
  logic [1:0]  grant_b;
  logic        tx_start_b;
  logic [7:0]  tx_data_b;
  logic        busy_b;
  logic        err_b;
  logic [2:0]  dbg_b;

  uart_tx_arbiter #(.NUM_REQ(2), .DATA_BITS(8), .GAP_TICKS(16), .TIMEOUT_TICKS(8)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .req(req), .din(din),
    .grant(grant_a), .tx_start(tx_start_a), .tx_data(tx_data_a),
    .tx_done_tick(done), .busy(busy_a), .timeout_err(err_a), .state_dbg(dbg_a)
  );

  uart_tx_arbiter #(.NUM_REQ(2), .DATA_BITS(8), .GAP_TICKS(0), .TIMEOUT_TICKS(8)) dut_b (
    .clk(clk), .reset(reset), .tick(tick_b), .req(req_b), .din(din_b),
    .grant(grant_b), .tx_start(tx_start_b), .tx_data(tx_data_b),
    .tx_done_tick(done_b), .busy(busy_b), .timeout_err(err_b), .state_dbg(dbg_b)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // scoreboard
  logic [7:0] exp_q[$];
  logic [1:0] exp_grant_q[$];
  logic [7:0] e_data;
  logic [1:0] e_grant;
  int         grant_cyc = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (grant_a !== 2'b00) begin
        tests_run++;
        if (exp_grant_q.size() == 0) begin
          tests_failed++;
          $display("FAIL grant_unexpected: got %b, expected no grant", grant_a);
        end else begin
          e_grant = exp_grant_q.pop_front();
          if (grant_a !== e_grant) begin
            tests_failed++;
            $display("FAIL grant_order: got %b, expected %b", grant_a, e_grant);
          end
        end
        grant_cyc = cyc;
      end
      if (tx_start_a === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL start_unexpected: tx_data %h, expected no tx_start", tx_data_a);
        end else begin
          e_data = exp_q.pop_front();
          if (tx_data_a !== e_data) begin
            tests_failed++;
            $display("FAIL tx_data: got %h, expected %h", tx_data_a, e_data);
          end
        end
        tests_run++;
        if (cyc - grant_cyc !== 2) begin
          tests_failed++;
          $display("FAIL start_latency: got %0d clk after grant, expected 2", cyc - grant_cyc);
        end
      end
    end
  end

  // driver tasks
  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1; cyc_wait(1);
    tick = 1'b0; cyc_wait(1);
  endtask

  task automatic pulse_done();
    done = 1'b1; cyc_wait(1);
    done = 1'b0; cyc_wait(1);
  endtask

  task automatic apply_reset();
    reset = 1'b0; cyc_wait(3);
    reset = 1'b1; cyc_wait(1);
  endtask

  task automatic wait_start(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (tx_start_a === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      tests_run++; tests_failed++;
      $display("FAIL %s: got no tx_start in 200 clk, expected one", name);
    end
    @(posedge clk); #1;
  endtask

  // frame end plus a 16-tick gap; optional checks on the gap boundary
  task automatic finish_frame(input int pre, input bit chk);
    for (int i = 0; i < pre; i++) pulse_tick();
    pulse_done();
    for (int i = 0; i < 15; i++) pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    if (chk) begin
      tests_run++;
      if (busy_a !== 1'b1 || dbg_a !== 3'd4) begin
        tests_failed++;
        $display("FAIL gap_hold: busy %b state %0d, expected busy 1 state 4", busy_a, dbg_a);
      end
    end
    @(posedge clk); #1;
    tick = 1'b0;
    @(negedge clk);
    if (chk) begin
      tests_run++;
      if (busy_a !== 1'b0 || dbg_a !== 3'd0) begin
        tests_failed++;
        $display("FAIL gap_exit: busy %b state %0d, expected busy 0 state 0", busy_a, dbg_a);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc_wait(3);
    @(negedge clk);
    tests_run++;
    if ({grant_a, tx_start_a, tx_data_a, busy_a, err_a, dbg_a} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_a: got g=%b s=%b d=%h b=%b e=%b st=%0d, expected all 0",
               grant_a, tx_start_a, tx_data_a, busy_a, err_a, dbg_a);
    end
    tests_run++;
    if ({grant_b, tx_start_b, tx_data_b, busy_b, err_b, dbg_b} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_b: got g=%b s=%b d=%h b=%b e=%b st=%0d, expected all 0",
               grant_b, tx_start_b, tx_data_b, busy_b, err_b, dbg_b);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    cyc_wait(1);
  endtask

  task automatic test_single();
    exp_grant_q.push_back(2'b01);
    exp_q.push_back(8'hA5);
    req = 2'b01; din = 16'h00A5;
    wait_start("single");
    req = 2'b00;
    @(negedge clk);
    tests_run++;
    if (busy_a !== 1'b1 || dbg_a !== 3'd3) begin
      tests_failed++;
      $display("FAIL single_wait: busy %b state %0d, expected busy 1 state 3", busy_a, dbg_a);
    end
    @(posedge clk); #1;
    finish_frame(3, 1'b1);
  endtask

  task automatic test_round_robin();
    apply_reset();
    exp_grant_q.push_back(2'b01); exp_q.push_back(8'h11);
    exp_grant_q.push_back(2'b10); exp_q.push_back(8'h22);
    exp_grant_q.push_back(2'b01); exp_q.push_back(8'h11);
    exp_grant_q.push_back(2'b10); exp_q.push_back(8'h22);
    req = 2'b11; din = 16'h2211;
    for (int f = 0; f < 4; f++) begin
      wait_start("round_robin");
      if (f == 3) req = 2'b00;
      finish_frame(2, f == 0);
    end
    tests_run++;
    if (exp_q.size() != 0 || exp_grant_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rr_drain: %0d bytes %0d grants left, expected 0 and 0",
               exp_q.size(), exp_grant_q.size());
    end
  endtask

  task automatic test_gap_zero();
    bit seen;
    req_b = 2'b01; din_b = 16'h003C;
    @(negedge clk);
    tests_run++;
    if (grant_b !== 2'b01) begin
      tests_failed++;
      $display("FAIL g0_grant: got %b, expected 01", grant_b);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_start_b === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen || tx_data_b !== 8'h3C) begin
      tests_failed++;
      $display("FAIL g0_start: seen %b data %h, expected seen 1 data 3c", seen, tx_data_b);
    end
    @(posedge clk); #1;
    done_b = 1'b1;
    @(posedge clk); #1;
    done_b = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dbg_b !== 3'd4 || busy_b !== 1'b1 || grant_b !== 2'b00) begin
      tests_failed++;
      $display("FAIL g0_gap: state %0d busy %b grant %b, expected 4 1 00", dbg_b, busy_b, grant_b);
    end
    @(negedge clk);
    tests_run++;
    if (dbg_b !== 3'd0 || busy_b !== 1'b0 || grant_b !== 2'b01) begin
      tests_failed++;
      $display("FAIL g0_idle: state %0d busy %b grant %b, expected 0 0 01", dbg_b, busy_b, grant_b);
    end
    @(posedge clk); #1;
    req_b = 2'b00;
    cyc_wait(3);
    done_b = 1'b1; cyc_wait(1);
    done_b = 1'b0; cyc_wait(2);
    @(negedge clk);
    tests_run++;
    if (dbg_b !== 3'd0 || err_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL g0_return: state %0d err %b, expected 0 0", dbg_b, err_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    exp_grant_q.push_back(2'b10);
    exp_q.push_back(8'h5A);
    req = 2'b10; din = 16'h5A00;
    wait_start("timeout");
    req = 2'b00;
    for (int i = 0; i < 7; i++) pulse_tick();
    @(negedge clk);
    tests_run++;
    if (err_a !== 1'b0 || dbg_a !== 3'd3) begin
      tests_failed++;
      $display("FAIL timeout_early: err %b state %0d, expected 0 3", err_a, dbg_a);
    end
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(negedge clk);
    tests_run++;
    if (err_a !== 1'b1 || dbg_a !== 3'd4) begin
      tests_failed++;
      $display("FAIL timeout_set: err %b state %0d, expected 1 4", err_a, dbg_a);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) pulse_tick();
    @(negedge clk);
    tests_run++;
    if (dbg_a !== 3'd0) begin
      tests_failed++;
      $display("FAIL timeout_idle: state %0d, expected 0", dbg_a);
    end
    @(posedge clk); #1;
    exp_grant_q.push_back(2'b01);
    exp_q.push_back(8'h77);
    req = 2'b01; din = 16'h0077;
    wait_start("after_timeout");
    req = 2'b00;
    finish_frame(2, 1'b0);
    @(negedge clk);
    tests_run++;
    if (err_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_sticky: err %b, expected 1", err_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_coincident();
    exp_grant_q.push_back(2'b01);
    exp_q.push_back(8'h0F);
    req = 2'b01; din = 16'h000F;
    wait_start("coincident");
    req = 2'b00;
    pulse_tick(); pulse_tick();
    tick = 1'b1; done = 1'b1; cyc_wait(1);
    tick = 1'b0; done = 1'b0; cyc_wait(1);
    for (int i = 0; i < 15; i++) pulse_tick();
    @(negedge clk);
    tests_run++;
    if (dbg_a !== 3'd4 || busy_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL coinc_gap15: state %0d busy %b, expected 4 1", dbg_a, busy_a);
    end
    @(posedge clk); #1;
    tick = 1'b1; cyc_wait(1);
    tick = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dbg_a !== 3'd0) begin
      tests_failed++;
      $display("FAIL coinc_gap16: state %0d, expected 0", dbg_a);
    end
    @(posedge clk); #1;
    done = 1'b1;
    @(negedge clk);
    tests_run++;
    if (grant_a !== 2'b00 || tx_start_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL spurious_pulse: grant %b start %b, expected 00 0", grant_a, tx_start_a);
    end
    @(posedge clk); #1;
    done = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dbg_a !== 3'd0 || busy_a !== 1'b0 || tx_data_a !== 8'h0F) begin
      tests_failed++;
      $display("FAIL spurious_state: state %0d busy %b data %h, expected 0 0 0f",
               dbg_a, busy_a, tx_data_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_grant_q.push_back(2'b01);
    exp_q.push_back(8'h99);
    req = 2'b01; din = 16'h0099;
    wait_start("reset_mid_first");
    req = 2'b00;
    pulse_tick();
    reset = 1'b0;
    req = 2'b10; din = 16'hC300;
    #2;
    tests_run++;
    if ({grant_a, tx_start_a, tx_data_a, busy_a, err_a, dbg_a} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_async: got g=%b s=%b d=%h b=%b e=%b st=%0d, expected all 0",
               grant_a, tx_start_a, tx_data_a, busy_a, err_a, dbg_a);
    end
    cyc_wait(2);
    @(negedge clk);
    tests_run++;
    if ({grant_a, tx_start_a, busy_a, dbg_a} !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_hold: got g=%b s=%b b=%b st=%0d, expected all 0",
               grant_a, tx_start_a, busy_a, dbg_a);
    end
    @(posedge clk); #1;
    exp_grant_q.push_back(2'b10);
    exp_q.push_back(8'hC3);
    reset = 1'b1;
    wait_start("reset_mid_second");
    req = 2'b00;
    finish_frame(2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_gap_zero();
    test_timeout();
    test_coincident();
    test_reset_mid();
    cyc_wait(4);
    tests_run++;
    if (exp_q.size() != 0 || exp_grant_q.size() != 0) begin
      tests_failed++;
      $display("FAIL final_drain: %0d bytes %0d grants left, expected 0 and 0",
               exp_q.size(), exp_grant_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
